game_controller: RTL
====================

// Module: game_controller
// PURPOSE
//  Sequencer for the pong datapath. Generates the row-scan index (count) and paddle column
//  (player_down) consumed by game_process. Owns game state: paddle motion, ball position and
//  velocity, wall/paddle bounce, miss detection and scoring. Sits between button inputs and the
//  8x8 matrix renderer.
// PARAMETERS
//  SIZE      2     paddle width in columns
//  WIDTH     8     matrix width; play field is columns/rows 1..WIDTH-2
//  SCAN_DIV  4     clk cycles per row_count step (>=1)
//  TICK_DIV  1024  clk cycles per game tick (>=2)
//  MISS_HOLD 4     game ticks spent in MISS before re-serve
//  MAX_MISS  3     misses that end the game (<=15)
// PORTS
//  clk          in   1  system clock, all flops rising edge
//  rst_n        in   1  asynchronous active-low reset
//  btn_left     in   1  raw button, paddle toward column 1
//  btn_right    in   1  raw button, paddle toward column WIDTH-2
//  btn_start    in   1  raw button, serve / restart
//  count        out  3  row scan index to renderer
//  player_down  out  3  leftmost paddle column, range 1..WIDTH-1-SIZE
//  ball_x       out  3  ball column 1..WIDTH-2
//  ball_y       out  3  ball row 1..WIDTH-2 (row WIDTH-1 = paddle row)
//  state        out  2  00 SERVE, 01 PLAY, 10 MISS, 11 OVER
//  miss_count   out  4  misses since last restart
//  tick         out  1  one-cycle pulse on each game tick
// BEHAVIOUR
//  Reset: count=0, player_down=(WIDTH-SIZE)/2 (=3), ball_x=WIDTH/2-1 (=3), ball_y=1, dx=+1, dy=+1,
//   state=SERVE, miss_count=0, tick=0, dividers=0, synchronizers=0. Async assert, sync deassert use.
//  Buttons: 2-flop synchronized; all decisions use synchronized values (2-cycle input latency).
//  Scan: scan divider counts 0..SCAN_DIV-1; at wrap count<=count+1 (7->0 wrap), in all states.
//  Tick: tick divider counts 0..TICK_DIV-1; tick=1 for the cycle after divider reaches TICK_DIV-1.
//  All game updates below happen only in a cycle with tick=1, using pre-tick register values.
//  Paddle (SERVE, PLAY): left xor right -> move 1, saturating at 1 and WIDTH-1-SIZE; both/neither -> hold.
//  SERVE: ball held at (3,1), dx=+1, dy=+1. btn_start high on tick -> PLAY.
//  PLAY, per tick, x and y evaluated independently:
//   x: ball_x==1 with dx=-1, or ball_x==WIDTH-2 with dx=+1 -> negate dx, ball_x unchanged this tick;
//      else ball_x+=dx.
//   y: ball_y==1 with dy=-1 -> dy=+1, hold. ball_y==WIDTH-2 with dy=+1 -> paddle check against
//      OLD player_down: player_down<=ball_x<=player_down+SIZE-1 -> dy=-1, hold; else -> MISS,
//      miss_count+1. Else ball_y+=dy.
//   Corner (both limits): both components reflect on the same tick.
//  MISS: hold counter counts MISS_HOLD ticks; then SERVE if miss_count<MAX_MISS, else OVER. Paddle frozen.
//  OVER: everything frozen except scan. btn_start on tick -> miss_count=0, ball reset, SERVE.
//  miss_count saturates at 15. btn_start outside SERVE/OVER is ignored.
//  Reset asserted mid-game: all registers return to reset values immediately, no partial tick.
// STRUCTURE
//  Shared package pong_pkg: state encodings (ST_SERVE..ST_OVER), SIZE/WIDTH defaults, field limits
//   FIELD_MIN=1, FIELD_MAX=WIDTH-2, PADDLE_MAX=WIDTH-1-SIZE, shared by game_process.
//  One sub-module: pulse_divider (param DIV; clk, rst_n -> one-cycle pulse), instanced for scan and tick.
//  Synchronizers, paddle, ball and FSM logic stay in this module.
// TESTING (TICK_DIV=8, SCAN_DIV=1 for sim)
//  Reset release -> count steps 0..7,0; player_down=3, ball=(3,1), state=SERVE, tick every 8 clk.
//  btn_left held 5 ticks -> player_down 3,2,1,1,1; btn_left+btn_right together -> no movement.
//  btn_start -> PLAY; ball path (3,1)->(4,2)->(5,3)->(6,4)->(6,5) with dx=-1, corner reflects both.
//  player_down=5, ball arrives (6,6) with dy=+1 -> dy=-1, state stays PLAY, miss_count=0.
//  player_down=1, ball at (6,6) falling -> MISS, miss_count=1, SERVE after 4 ticks.
//  3 misses -> OVER; btn_start -> miss_count=0, SERVE. rst_n pulse mid-PLAY -> all reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong state encodings and play-field geometry
// Purpose: game state encoding, default geometry and field limits shared by
//          game_controller and game_process.
// Ports:   none (package).
package pong_pkg;

  localparam int SIZE_DEF  = 2;
  localparam int WIDTH_DEF = 8;

  // Play field occupies columns/rows FIELD_MIN..FIELD_MAX; row WIDTH-1 is the paddle row.
  localparam int FIELD_MIN = 1;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_MISS  = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  function automatic int field_max(input int width);
    return width - 2;
  endfunction

  // Rightmost legal leftmost-paddle column.
  function automatic int paddle_max(input int width, input int size);
    return width - 1 - size;
  endfunction

  localparam int FIELD_MAX  = field_max(WIDTH_DEF);
  localparam int PADDLE_MAX = paddle_max(WIDTH_DEF, SIZE_DEF);

endpackage

// File: rtl/pulse_divider.sv
// rtl/pulse_divider.sv - free-running divider emitting a one-cycle pulse
// Purpose: counts 0..DIV-1 and raises pulse for the cycle after the count
//          reaches DIV-1, giving one pulse every DIV clocks.
// Ports:   clk   in  system clock
//          rst_n in  asynchronous active-low reset
//          pulse out one-cycle pulse, registered
module pulse_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    pulse_d = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - pong sequencer: scan index, paddle, ball and scoring FSM
// Purpose: synchronizes buttons, generates the row-scan index and game tick,
//          and advances paddle, ball, bounce, miss and score once per tick.
// Ports:   clk, rst_n                     clock, asynchronous active-low reset
//          btn_left/btn_right/btn_start   raw buttons (2-flop synchronized)
//          count        row scan index to renderer
//          player_down  leftmost paddle column
//          ball_x/ball_y ball position in the play field
//          state        00 SERVE, 01 PLAY, 10 MISS, 11 OVER
//          miss_count   misses since last restart (saturates at 15)
//          tick         one-cycle pulse per game tick
module game_controller
  import pong_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SCAN_DIV  = 4,
  parameter int TICK_DIV  = 1024,
  parameter int MISS_HOLD = 4,
  parameter int MAX_MISS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [2:0] count,
  output logic [2:0] player_down,
  output logic [2:0] ball_x,
  output logic [2:0] ball_y,
  output logic [1:0] state,
  output logic [3:0] miss_count,
  output logic       tick
);

  localparam int HW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

  localparam logic [2:0]    F_LO      = 3'(FIELD_MIN);
  localparam logic [2:0]    F_HI      = 3'(field_max(WIDTH));
  localparam logic [2:0]    P_HI      = 3'(paddle_max(WIDTH, SIZE));
  localparam logic [2:0]    P_RST     = 3'((WIDTH - SIZE) / 2);
  localparam logic [2:0]    X_RST     = 3'(WIDTH / 2 - 1);
  localparam logic [3:0]    PAD_SPAN  = 4'(SIZE - 1);
  localparam logic [3:0]    MISS_END  = 4'(MAX_MISS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MISS_HOLD - 1);

  // Button synchronizers, bit order {start, right, left}.
  logic [2:0] btn_s1_q, btn_s1_d;
  logic [2:0] btn_s2_q, btn_s2_d;
  logic       left_s, right_s, start_s;

  logic scan_p, tick_p;

  logic [2:0]    count_q, count_d;
  game_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    pad_q, pad_d;
  logic [2:0]    bx_q, bx_d;
  logic [2:0]    by_q, by_d;
  logic          dxn_q, dxn_d;  // 1: ball moving toward column FIELD_MIN
  logic          dyn_q, dyn_d;  // 1: ball moving toward row FIELD_MIN
  logic [3:0]    miss_q, miss_d;

  logic paddle_hit, x_wall, at_bottom, miss_hit;

  pulse_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (scan_p)
  );

  pulse_divider #(.DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (tick_p)
  );

  always_comb begin
    btn_s1_d = {btn_start, btn_right, btn_left};
    btn_s2_d = btn_s1_q;
    count_d  = scan_p ? count_q + 3'd1 : count_q;
  end

  assign left_s  = btn_s2_q[0];
  assign right_s = btn_s2_q[1];
  assign start_s = btn_s2_q[2];

  // Collision decode on pre-tick values; the paddle check uses the paddle
  // position from before this tick's move.
  always_comb begin
    paddle_hit = ({1'b0, pad_q} <= {1'b0, bx_q}) &&
                 ({1'b0, bx_q} <= ({1'b0, pad_q} + PAD_SPAN));
    x_wall     = (bx_q == F_LO && dxn_q) || (bx_q == F_HI && !dxn_q);
    at_bottom  = (by_q == F_HI) && !dyn_q;
    miss_hit   = (state_q == ST_PLAY) && at_bottom && !paddle_hit;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SERVE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (tick_p) begin
      case (state_q)
        ST_SERVE: if (start_s) state_d = ST_PLAY;
        ST_PLAY: begin
          if (miss_hit) begin
            state_d = ST_MISS;
            hold_d  = '0;
          end
        end
        ST_MISS: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            // miss_q already includes the miss that entered this state.
            state_d = (miss_q >= MISS_END) ? ST_OVER : ST_SERVE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_OVER: if (start_s) state_d = ST_SERVE;
        default: state_d = ST_SERVE;
      endcase
    end
  end

  // FSM outputs: paddle, ball and score updates.
  always_comb begin
    pad_d  = pad_q;
    bx_d   = bx_q;
    by_d   = by_q;
    dxn_d  = dxn_q;
    dyn_d  = dyn_q;
    miss_d = miss_q;
    if (tick_p) begin
      if ((state_q == ST_SERVE || state_q == ST_PLAY) && (left_s ^ right_s)) begin
        if (left_s && pad_q != F_LO) begin
          pad_d = pad_q - 3'd1;
        end else if (right_s && pad_q != P_HI) begin
          pad_d = pad_q + 3'd1;
        end
      end

      if (state_q == ST_PLAY) begin
        if (x_wall) begin
          dxn_d = !dxn_q;
        end else begin
          bx_d = dxn_q ? bx_q - 3'd1 : bx_q + 3'd1;
        end

        if (by_q == F_LO && dyn_q) begin
          dyn_d = 1'b0;
        end else if (at_bottom) begin
          if (paddle_hit) begin
            dyn_d = 1'b1;
          end else begin
            miss_d = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
          end
        end else begin
          by_d = dyn_q ? by_q - 3'd1 : by_q + 3'd1;
        end
      end

      if (state_q == ST_OVER && start_s) begin
        miss_d = '0;
      end

      // Any tick that lands in SERVE (re-serve, restart or waiting) parks the ball.
      if (state_d == ST_SERVE) begin
        bx_d  = X_RST;
        by_d  = F_LO;
        dxn_d = 1'b0;
        dyn_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      count_q  <= '0;
      pad_q    <= P_RST;
      bx_q     <= X_RST;
      by_q     <= F_LO;
      dxn_q    <= 1'b0;
      dyn_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      count_q  <= count_d;
      pad_q    <= pad_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dxn_q    <= dxn_d;
      dyn_q    <= dyn_d;
      miss_q   <= miss_d;
    end
  end

  assign count       = count_q;
  assign player_down = pad_q;
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign state       = state_q;
  assign miss_count  = miss_q;
  assign tick        = tick_p;

endmodule
